// File: rtl/uart_level_fifo.sv
// rtl/uart_level_fifo.sv - parametrised UART FIFO with level threshold and sticky error flags
// Read path is either registered (1-cycle latency) or show-ahead, selected by SHOW_AHEAD.
module uart_level_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter bit SHOW_AHEAD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  input  logic [ADDR_W:0]   thresh,
  output logic              level_hit,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic              ovf_set;
  logic              udf_set;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign level_hit = (thresh != '0) && (count >= thresh);

  // Full/empty are judged on the registered count, so a pop cannot make room for a same-cycle push.
  assign wr_acc  = wr_en && !full  && !flush;
  assign rd_acc  = rd_en && !empty && !flush;
  assign ovf_set = wr_en && full   && !flush;
  assign udf_set = rd_en && empty  && !flush;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A new error event in the same cycle as err_clr must not be lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (udf_set) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

  generate
    if (SHOW_AHEAD) begin : g_show_ahead
      assign rd_data  = mem[rd_ptr];
      assign rd_valid = !empty;
    end else begin : g_registered
      logic [DATA_W-1:0] rd_data_q;
      logic              rd_valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) begin
            rd_data_q <= mem[rd_ptr];
          end
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_uart_level_fifo.sv
// tb/tb_uart_level_fifo.sv - scoreboard bench for uart_level_fifo, registered and show-ahead builds
// Registered-mode read data is checked by a negedge monitor against a queue filled at issue time.
module tb_uart_level_fifo;

  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic          flush0, wr_en0, rd_en0, err_clr0;
  logic [DW-1:0] wr_data0, rd_data0;
  logic [AW:0]   thresh0, count0;
  logic          rd_valid0, full0, empty0, level_hit0, overflow0, underflow0;

  logic          flush1, wr_en1, rd_en1, err_clr1;
  logic [DW-1:0] wr_data1, rd_data1;
  logic [AW:0]   thresh1, count1;
  logic          rd_valid1, full1, empty1, level_hit1, overflow1, underflow1;

  uart_level_fifo #(.DATA_W(DW), .DEPTH(16), .SHOW_AHEAD(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush0), .wr_en(wr_en0), .wr_data(wr_data0),
    .rd_en(rd_en0), .rd_data(rd_data0), .rd_valid(rd_valid0), .count(count0),
    .full(full0), .empty(empty0), .thresh(thresh0), .level_hit(level_hit0),
    .overflow(overflow0), .underflow(underflow0), .err_clr(err_clr0)
  );

  uart_level_fifo #(.DATA_W(DW), .DEPTH(16), .SHOW_AHEAD(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .wr_en(wr_en1), .wr_data(wr_data1),
    .rd_en(rd_en1), .rd_data(rd_data1), .rd_valid(rd_valid1), .count(count1),
    .full(full1), .empty(empty1), .thresh(thresh1), .level_hit(level_hit1),
    .overflow(overflow1), .underflow(underflow1), .err_clr(err_clr1)
  );

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_valid0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_valid_unexpected actual=%0h expected=none at %0t", rd_data0, $time);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (rd_data0 !== e) begin
          failures++;
          $display("FAIL rd_data actual=%0h expected=%0h at %0t", rd_data0, e, $time);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [DW-1:0] d);
    wr_en0 = 1'b1; wr_data0 = d;
    step();
    wr_en0 = 1'b0;
  endtask

  task automatic pop0(input logic [DW-1:0] e);
    rd_en0 = 1'b1;
    exp_q.push_back(e);
    step();
    rd_en0 = 1'b0;
  endtask

  task automatic push1(input logic [DW-1:0] d);
    wr_en1 = 1'b1; wr_data1 = d;
    step();
    wr_en1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    {flush0, wr_en0, rd_en0, err_clr0, flush1, wr_en1, rd_en1, err_clr1} = '0;
    wr_data0 = '0; wr_data1 = '0;
    thresh0 = 5'd4; thresh1 = 5'd0;
    #12;
    chk("rst_count", count0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_full", full0, 0);
    chk("rst_level_hit", level_hit0, 0);
    chk("rst_rd_valid", rd_valid0, 0);
    chk("rst_rd_data", rd_data0, 0);
    chk("rst_overflow", overflow0, 0);
    chk("rst_underflow", underflow0, 0);
    chk("rst_sa_rd_valid", rd_valid1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      wr_en0 = 1'b1; wr_data0 = 8'(i);
      step();
      chk("fill_count", count0, i + 1);
      chk("fill_level_hit", level_hit0, (i + 1 >= 4) ? 1 : 0);
    end
    chk("fill_full", full0, 1);
    wr_data0 = 8'hAA;
    step();
    wr_en0 = 1'b0;
    chk("ovf_set", overflow0, 1);
    chk("ovf_count", count0, 16);
    thresh0 = 5'd0;
    #1;
    chk("thresh0_no_hit", level_hit0, 0);
    thresh0 = 5'd4;

    for (int i = 0; i < 16; i++) begin
      rd_en0 = 1'b1;
      exp_q.push_back(8'(i));
      step();
      chk("drain_count", count0, 15 - i);
      chk("drain_level_hit", level_hit0, (15 - i >= 4) ? 1 : 0);
    end
    step();
    rd_en0 = 1'b0;
    chk("udf_set", underflow0, 1);
    chk("udf_rd_valid", rd_valid0, 0);
    chk("udf_rd_data_hold", rd_data0, 8'h0F);
    chk("drain_empty", empty0, 1);

    err_clr0 = 1'b1;
    step();
    err_clr0 = 1'b0;
    chk("clr_overflow", overflow0, 0);
    chk("clr_underflow", underflow0, 0);

    for (int i = 0; i < 10; i++) push0(8'h30 + 8'(i));
    for (int i = 0; i < 10; i++) pop0(8'h30 + 8'(i));
    for (int i = 0; i < 10; i++) push0(8'h40 + 8'(i));
    for (int i = 0; i < 10; i++) pop0(8'h40 + 8'(i));
    chk("wrap_count", count0, 0);

    for (int i = 0; i < 5; i++) push0(8'h50 + 8'(i));
    wr_en0 = 1'b1; rd_en0 = 1'b1; wr_data0 = 8'h55;
    exp_q.push_back(8'h50);
    step();
    wr_en0 = 1'b0; rd_en0 = 1'b0;
    chk("simul_count", count0, 5);
    for (int i = 1; i < 6; i++) pop0(8'h50 + 8'(i));
    chk("simul_drain_count", count0, 0);

    for (int i = 0; i < 16; i++) push0(8'h60 + 8'(i));
    chk("full2", full0, 1);
    wr_en0 = 1'b1; rd_en0 = 1'b1; wr_data0 = 8'hBB;
    exp_q.push_back(8'h60);
    step();
    wr_en0 = 1'b0; rd_en0 = 1'b0;
    chk("full_rw_count", count0, 15);
    chk("full_rw_overflow", overflow0, 1);
    err_clr0 = 1'b1;
    step();
    err_clr0 = 1'b0;
    chk("err_clr_pulse", overflow0, 0);
    push0(8'h70);
    chk("full3", full0, 1);
    wr_en0 = 1'b1; wr_data0 = 8'hCC; err_clr0 = 1'b1;
    step();
    wr_en0 = 1'b0; err_clr0 = 1'b0;
    chk("set_wins_clr", overflow0, 1);
    chk("set_wins_count", count0, 16);
    for (int i = 1; i < 16; i++) pop0(8'h60 + 8'(i));
    pop0(8'h70);
    chk("drain3_empty", empty0, 1);

    push0(8'h11);
    push0(8'h22);
    wr_en0 = 1'b1; rd_en0 = 1'b1; flush0 = 1'b1; wr_data0 = 8'hDD;
    step();
    wr_en0 = 1'b0; rd_en0 = 1'b0; flush0 = 1'b0;
    chk("flush_count", count0, 0);
    chk("flush_empty", empty0, 1);
    chk("flush_overflow_kept", overflow0, 1);
    chk("flush_no_underflow", underflow0, 0);
    chk("flush_rd_valid", rd_valid0, 0);
    chk("flush_rd_data_hold", rd_data0, 8'h70);
    push0(8'h33);
    pop0(8'h33);
    step();

    push1(8'h5A);
    chk("sa_valid", rd_valid1, 1);
    chk("sa_data", rd_data1, 8'h5A);
    push1(8'h5B);
    chk("sa_data_head", rd_data1, 8'h5A);
    chk("sa_count2", count1, 2);
    rd_en1 = 1'b1;
    step();
    rd_en1 = 1'b0;
    chk("sa_pop_data", rd_data1, 8'h5B);
    chk("sa_pop_count", count1, 1);
    wr_en1 = 1'b1; rd_en1 = 1'b1; flush1 = 1'b1; wr_data1 = 8'hEE;
    step();
    wr_en1 = 1'b0; rd_en1 = 1'b0; flush1 = 1'b0;
    chk("sa_flush_count", count1, 0);
    chk("sa_flush_empty", empty1, 1);
    chk("sa_flush_valid", rd_valid1, 0);
    chk("sa_flush_ovf", overflow1, 0);
    chk("sa_flush_udf", underflow1, 0);
    rd_en1 = 1'b1;
    step();
    rd_en1 = 1'b0;
    chk("sa_underflow", underflow1, 1);
    push1(8'h79);

    push0(8'h77);
    push0(8'h78);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", count0, 0);
    chk("async_rst_empty", empty0, 1);
    chk("async_rst_overflow", overflow0, 0);
    chk("async_rst_rd_data", rd_data0, 0);
    chk("async_rst_sa_count", count1, 0);
    chk("async_rst_sa_valid", rd_valid1, 0);
    chk("async_rst_sa_udf", underflow1, 0);
    #20;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
